datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 mdata  input  16  memory data writeback source.
REQ-004 sximm8  input  16  sign-extended imm8 from instruction_decoder.
REQ-005 sximm5  input  16  sign-extended imm5 from instruction_decoder.
REQ-006 PC  input  8  program counter; zero-extended to 16 bits on writeback.
REQ-007 vsel  input  2  writeback select: 00 C, 01 PC, 10 sximm8, 11 mdata.
REQ-008 writenum  input  3  register file write index.
REQ-009 write  input  1  register file write enable.
REQ-010 readnum  input  3  register file read index.
REQ-011 loada  input  1  load enable for pipeline register A.
REQ-012 loadb  input  1  load enable for pipeline register B.
REQ-013 asel  input  1  ALU A-input select: 1 selects 16'h0000, 0 selects A.
REQ-014 bsel  input  1  ALU B-input select: 1 selects sximm5, 0 selects shifter output.
REQ-015 shift  input  2  shifter operation applied to B.
REQ-016 ALUop  input  2  ALU operation: 00 add, 01 sub, 10 AND, 11 NOT Bin.
REQ-017 loadc  input  1  load enable for result register C.
REQ-018 loads  input  1  load enable for status register.
REQ-019 datapath_out  output  16  contents of register C.
REQ-020 Z_out  output  1  registered zero flag.
REQ-021 N_out  output  1  registered negative flag.
REQ-022 V_out  output  1  registered signed-overflow flag.

Function
REQ-023 The register file SHALL be 8 x 16-bit (R0-R7); write=1 at a rising edge stores the vsel-selected value into R[writenum].
REQ-024 Register file reads SHALL be combinational: data_out = R[readnum].
REQ-025 A SHALL load data_out when loada=1 and B SHALL load data_out when loadb=1; both hold otherwise and may load in the same cycle.
REQ-026 Shifter SHALL implement: 00 pass, 01 left by 1 with LSB 0, 10 logical right by 1 with MSB 0, 11 arithmetic right by 1 with MSB preserved.
REQ-027 ALU SHALL compute 16-bit results with carry-out discarded; add/sub wrap modulo 2^16.
REQ-028 Z SHALL be 1 iff the ALU result is 0; N SHALL equal result[15].
REQ-029 V SHALL be signed two's-complement overflow for add/sub and 0 for AND and NOT.
REQ-030 C SHALL load the ALU result when loadc=1; status SHALL load {Z,N,V} when loads=1; loadc and loads together capture the same result.
REQ-031 Latency: register read to A/B 1 cycle, A/B to C 1 cycle, C to register file via vsel=00 1 cycle.
REQ-032 Write and load of the same register in one cycle: A/B SHALL capture the pre-write value unless REGFILE_BYPASS_EN is defined.
REQ-033 datapath_out and flag outputs SHALL change only at rising clock edges.

Reset
REQ-034 reset=1 at a rising edge SHALL clear R0-R7, A, B, C, Z_out, N_out and V_out to 0.
REQ-035 reset SHALL take priority over write, loada, loadb, loadc and loads in the same cycle; it may be asserted mid-operation with no partial update.

Configuration
REQ-036 With REGFILE_BYPASS_EN defined, when write=1 and readnum==writenum, data_out SHALL equal the value being written; without it, data_out SHALL always be the stored value.

Verification
REQ-037 Write R0=0x0007 and R1=0x0002 via vsel=10, then load A=R0 and B=R1, shift=00, ALUop=00, loadc, loads -> datapath_out=0x0009, Z/N/V=0/0/0; write back to R2 via vsel=00 and read R2 -> 0x0009.
REQ-038 A=0x8000, B=0x0001, ALUop=01 -> datapath_out=0x7FFF, V=1, N=0, Z=0.
REQ-039 B=0x8001, asel=1, ALUop=00, with shift=01/10/11 -> 0x0002 / 0x4000 / 0xC000.
REQ-040 A=0x0005, B=0x0005, ALUop=01 -> datapath_out=0x0000, Z=1; ALUop=11 with B=0x00FF -> 0xFF00, N=1, V=0.
REQ-041 R3=0x1111, then write R3=0x2222 with loada, readnum=3 in the same cycle -> A=0x1111 without the macro, A=0x2222 with REGFILE_BYPASS_EN.
REQ-042 Assert reset for one cycle after C=0x0009, with loadc=1 in the same cycle -> datapath_out=0x0000, flags 0, and every register reads 0x0000.

Source files
------------

// File: rtl/datapath.sv
// Register-file datapath: 8x16 register file, A/B operand registers, shifter, ALU, C and status registers.
// Optional macro REGFILE_BYPASS_EN forwards the value being written to a same-index combinational read.
module datapath #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mdata,
  input  logic [DATA_W-1:0] sximm8,
  input  logic [DATA_W-1:0] sximm5,
  input  logic [7:0]        PC,
  input  logic [1:0]        vsel,
  input  logic [2:0]        writenum,
  input  logic              write,
  input  logic [2:0]        readnum,
  input  logic              loada,
  input  logic              loadb,
  input  logic              asel,
  input  logic              bsel,
  input  logic [1:0]        shift,
  input  logic [1:0]        ALUop,
  input  logic              loadc,
  input  logic              loads,
  output logic [DATA_W-1:0] datapath_out,
  output logic              Z_out,
  output logic              N_out,
  output logic              V_out
);

  function automatic logic signed [DATA_W-1:0] shift_f(
    input logic signed [DATA_W-1:0] b,
    input logic [1:0]               op
  );
    logic signed [DATA_W-1:0] r;
    r = b;
    case (op)
      2'b01:   r = b <<< 1;
      2'b10:   r = $signed({1'b0, b[DATA_W-1:1]});
      2'b11:   r = b >>> 1;
      default: r = b;
    endcase
    return r;
  endfunction

  // Returns {overflow, result}; overflow only meaningful for add/sub.
  function automatic logic [DATA_W:0] alu_f(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [1:0]               op
  );
    logic signed [DATA_W-1:0] r;
    logic                     v;
    r = '0;
    v = 1'b0;
    case (op)
      2'b00: begin
        r = a + b;
        v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      2'b01: begin
        r = a - b;
        v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      2'b10:   r = a & b;
      default: r = ~b;
    endcase
    return {v, r};
  endfunction

  logic        [DATA_W-1:0] rf_q [8];
  logic        [DATA_W-1:0] wb_data;
  logic        [DATA_W-1:0] data_out;
  logic signed [DATA_W-1:0] a_q, a_d;
  logic signed [DATA_W-1:0] b_q, b_d;
  logic signed [DATA_W-1:0] c_q, c_d;
  logic                     z_q, z_d, n_q, n_d, v_q, v_d;
  logic signed [DATA_W-1:0] ain, bin, sh_out;
  logic        [DATA_W:0]   alu_res;

  always_comb begin
    wb_data = c_q;
    case (vsel)
      2'b01:   wb_data = {{(DATA_W-8){1'b0}}, PC};
      2'b10:   wb_data = sximm8;
      2'b11:   wb_data = mdata;
      default: wb_data = c_q;
    endcase
  end

`ifdef REGFILE_BYPASS_EN
  assign data_out = (write && (readnum == writenum)) ? wb_data : rf_q[readnum];
`else
  assign data_out = rf_q[readnum];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (write) begin
      rf_q[writenum] <= wb_data;
    end
  end

  // Operand stage: A/B capture the register-file read
  assign a_d = loada ? $signed(data_out) : a_q;
  assign b_d = loadb ? $signed(data_out) : b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Execute stage: shifter, operand muxes, ALU into C and status
  assign sh_out  = shift_f(b_q, shift);
  assign ain     = asel ? '0 : a_q;
  assign bin     = bsel ? $signed(sximm5) : sh_out;
  assign alu_res = alu_f(ain, bin, ALUop);

  assign c_d = loadc ? $signed(alu_res[DATA_W-1:0]) : c_q;
  assign z_d = loads ? (alu_res[DATA_W-1:0] == '0) : z_q;
  assign n_d = loads ? alu_res[DATA_W-1] : n_q;
  assign v_d = loads ? alu_res[DATA_W] : v_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;
  assign V_out        = v_q;

endmodule

// File: tb/tb_datapath.sv
// Directed testbench for datapath; flags are compared packed as {Z,N,V}.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mdata, sximm8, sximm5;
  logic [7:0]  PC;
  logic [1:0]  vsel, shift, ALUop;
  logic [2:0]  writenum, readnum;
  logic        write, loada, loadb, asel, bsel, loadc, loads;
  logic [15:0] datapath_out;
  logic        Z_out, N_out, V_out;

  int n_cmp = 0;
  int n_err = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [15:0] EXP_A41 = 16'h2222;
`else
  localparam logic [15:0] EXP_A41 = 16'h1111;
`endif

  datapath dut (
    .clk(clk), .reset(reset), .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5),
    .PC(PC), .vsel(vsel), .writenum(writenum), .write(write), .readnum(readnum),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(ALUop), .loadc(loadc), .loads(loads), .datapath_out(datapath_out),
    .Z_out(Z_out), .N_out(N_out), .V_out(V_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] exp_out, input logic [2:0] exp_znv);
    chk({tag, ".out"}, datapath_out, exp_out);
    chk({tag, ".znv"}, {13'h0, Z_out, N_out, V_out}, {13'h0, exp_znv});
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] v);
    vsel = 2'b10; sximm8 = v; writenum = r; write = 1'b1;
    tick;
    write = 1'b0;
  endtask

  task automatic lda(input logic [2:0] r);
    readnum = r; loada = 1'b1;
    tick;
    loada = 1'b0;
  endtask

  task automatic ldb(input logic [2:0] r);
    readnum = r; loadb = 1'b1;
    tick;
    loadb = 1'b0;
  endtask

  task automatic op(input logic as, input logic bs, input logic [1:0] sh,
                    input logic [1:0] aop, input logic lc, input logic ls);
    asel = as; bsel = bs; shift = sh; ALUop = aop; loadc = lc; loads = ls;
    tick;
    loadc = 1'b0; loads = 1'b0;
  endtask

  task automatic readreg(input logic [2:0] r);
    ldb(r);
    op(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; mdata = '0; sximm8 = '0; sximm5 = '0; PC = '0;
    vsel = '0; shift = '0; ALUop = '0; writenum = '0; readnum = '0;
    write = 0; loada = 0; loadb = 0; asel = 0; bsel = 0; loadc = 0; loads = 0;
    tick;
    reset = 1'b0;
    chk_out("reset0", 16'h0000, 3'b000);

    // Add 7+2, write back through C, read it again
    wr(3'd0, 16'h0007);
    wr(3'd1, 16'h0002);
    lda(3'd0);
    ldb(3'd1);
    op(0, 0, 2'b00, 2'b00, 1, 1);
    chk_out("add7_2", 16'h0009, 3'b000);
    vsel = 2'b00; writenum = 3'd2; write = 1'b1;
    tick;
    write = 1'b0;
    readreg(3'd2);
    chk("rd_R2", datapath_out, 16'h0009);

    // Signed subtract overflow
    wr(3'd3, 16'h8000);
    wr(3'd4, 16'h0001);
    lda(3'd3);
    ldb(3'd4);
    op(0, 0, 2'b00, 2'b01, 1, 1);
    chk_out("sub_ovf", 16'h7FFF, 3'b001);

    // Shifter modes with asel forcing zero
    wr(3'd5, 16'h8001);
    ldb(3'd5);
    op(1, 0, 2'b01, 2'b00, 1, 1);
    chk("shl", datapath_out, 16'h0002);
    op(1, 0, 2'b10, 2'b00, 1, 1);
    chk("lsr", datapath_out, 16'h4000);
    op(1, 0, 2'b11, 2'b00, 1, 1);
    chk_out("asr", 16'hC000, 3'b010);

    // Zero result, NOT, AND, immediate operand, hold
    wr(3'd6, 16'h0005);
    lda(3'd6);
    ldb(3'd6);
    op(0, 0, 2'b00, 2'b01, 1, 1);
    chk_out("sub_zero", 16'h0000, 3'b100);
    wr(3'd7, 16'h00FF);
    ldb(3'd7);
    op(0, 0, 2'b00, 2'b11, 1, 1);
    chk_out("not", 16'hFF00, 3'b010);
    op(0, 0, 2'b00, 2'b10, 1, 1);
    chk_out("and", 16'h0005, 3'b000);
    sximm5 = 16'hFFFF;
    op(0, 1, 2'b00, 2'b00, 1, 1);
    chk_out("add_imm", 16'h0004, 3'b000);
    op(0, 0, 2'b00, 2'b11, 0, 0);
    chk_out("hold", 16'h0004, 3'b000);

    // Signed add overflow, then C load without status load
    wr(3'd4, 16'h7FFF);
    lda(3'd4);
    sximm5 = 16'h0001;
    op(0, 1, 2'b00, 2'b00, 1, 1);
    chk_out("add_ovf", 16'h8000, 3'b011);
    sximm5 = 16'h0000;
    op(0, 1, 2'b00, 2'b00, 1, 0);
    chk_out("c_only", 16'h7FFF, 3'b011);

    // Same-cycle write and load of R3
    wr(3'd3, 16'h1111);
    vsel = 2'b10; sximm8 = 16'h2222; writenum = 3'd3; write = 1'b1;
    readnum = 3'd3; loada = 1'b1;
    tick;
    write = 1'b0; loada = 1'b0;
    sximm5 = 16'h0000;
    op(0, 1, 2'b00, 2'b00, 1, 0);
    chk("wr_rd_A", datapath_out, EXP_A41);
    readreg(3'd3);
    chk("rd_R3", datapath_out, 16'h2222);

    // Reset mid-operation with every load asserted
    ldb(3'd7);
    op(1, 0, 2'b00, 2'b11, 0, 1);
    chk("pre_rst_flags", {13'h0, Z_out, N_out, V_out}, 16'h0002);
    lda(3'd0);
    ldb(3'd1);
    op(0, 0, 2'b00, 2'b00, 1, 0);
    chk_out("pre_rst", 16'h0009, 3'b010);
    reset = 1'b1; loadc = 1'b1; loads = 1'b1; write = 1'b1; loada = 1'b1; loadb = 1'b1;
    vsel = 2'b10; sximm8 = 16'h5A5A; writenum = 3'd6;
    tick;
    reset = 1'b0; loadc = 1'b0; loads = 1'b0; write = 1'b0; loada = 1'b0; loadb = 1'b0;
    chk_out("rst_mid", 16'h0000, 3'b000);
    op(0, 1, 2'b00, 2'b00, 1, 0);
    chk("rst_A", datapath_out, 16'h0000);
    for (int r = 0; r < 8; r++) begin
      readreg(3'(r));
      chk($sformatf("rst_R%0d", r), datapath_out, 16'h0000);
    end

    // PC and mdata writeback sources
    PC = 8'hA5; vsel = 2'b01; writenum = 3'd1; write = 1'b1;
    tick;
    write = 1'b0;
    readreg(3'd1);
    chk("wb_pc", datapath_out, 16'h00A5);
    mdata = 16'hBEEF; vsel = 2'b11; writenum = 3'd0; write = 1'b1;
    tick;
    write = 1'b0;
    readreg(3'd0);
    chk("wb_mdata", datapath_out, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
